// File: rtl/button_op_encoder.sv
// Front-panel encoder: synchronises and debounces three push-buttons and issues one
// 2-bit operation code per press, then waits for the counter's encoder_reset handshake.
module button_op_encoder #(
  parameter int DEBOUNCE_CYCLES = 100,
  parameter int CNT_W           = 16,
  parameter int ACK_TIMEOUT     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_madd,
  input  logic       btn_szero,
  input  logic       btn_reset,
  input  logic       encoder_reset,
  output logic [1:0] operation,
  output logic       busy,
  output logic       ack_err
);

  localparam int TMO_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, RELEASE} state_t;

  // bit 0 = minute_add, bit 1 = sec_to_zero, bit 2 = clock_reset
  logic [2:0]       raw;
  logic [2:0]       s1_q, s1_d, s2_q, s2_d;
  logic [2:0]       stable_q, stable_d, stable_hist_q, stable_hist_d;
  logic [2:0]       press_q, press_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  state_t           state_q, state_d;
  logic [1:0]       code_q, code_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             ack_err_q, ack_err_d;

  assign raw = {btn_reset, btn_szero, btn_madd};

  always_comb begin
    s1_d          = raw;
    s2_d          = s1_q;
    stable_d      = stable_q;
    stable_hist_d = stable_q;
    press_d       = stable_q & ~stable_hist_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_d[i] = s2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    tmo_d     = tmo_q;
    ack_err_d = ack_err_q;
    unique case (state_q)
      IDLE: begin
        if (|press_q) begin
          state_d = ISSUE;
          code_d  = press_q[2] ? 2'b11 : (press_q[1] ? 2'b01 : 2'b10);
        end
      end
      ISSUE: begin
        state_d = WAIT_ACK;
        tmo_d   = '0;
      end
      WAIT_ACK: begin
        if (encoder_reset) begin
          state_d = RELEASE;
        end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
          ack_err_d = 1'b1;
          state_d   = RELEASE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      RELEASE: begin
        // Hold off until every button is up so one press yields one code
        if (!encoder_reset && stable_q == 3'b000) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q          <= '0;
      s2_q          <= '0;
      stable_q      <= '0;
      stable_hist_q <= '0;
      press_q       <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      state_q       <= IDLE;
      code_q        <= 2'b00;
      tmo_q         <= '0;
      ack_err_q     <= 1'b0;
    end else begin
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      stable_q      <= stable_d;
      stable_hist_q <= stable_hist_d;
      press_q       <= press_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      state_q       <= state_d;
      code_q        <= code_d;
      tmo_q         <= tmo_d;
      ack_err_q     <= ack_err_d;
    end
  end

  assign operation = (state_q == ISSUE) ? code_q : 2'b00;
  assign busy      = (state_q != IDLE);
  assign ack_err   = ack_err_q;

endmodule

// File: tb/tb_button_op_encoder.sv
// Directed bench for button_op_encoder: press table plus hand-written handshake corners.
module tb_button_op_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_madd, btn_szero, btn_reset;
  logic       encoder_reset;
  logic [1:0] operation;
  logic       busy, ack_err;

  int checks = 0;
  int errors = 0;
  int op_cnt = 0;
  logic ack_en;

  button_op_encoder #(.DEBOUNCE_CYCLES(4), .CNT_W(16), .ACK_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .btn_madd(btn_madd), .btn_szero(btn_szero),
    .btn_reset(btn_reset), .encoder_reset(encoder_reset), .operation(operation),
    .busy(busy), .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  // Counter model: acknowledges one cycle after it sees a nonzero code
  always @(posedge clk) begin
    if (!rst_n) encoder_reset <= 1'b0;
    else        encoder_reset <= ack_en && (operation != 2'b00);
  end

  always @(negedge clk) if (operation != 2'b00) op_cnt++;

  typedef struct {
    logic [2:0] btns;   // {reset, szero, madd}
    logic [1:0] code;
    string      name;
  } vec_t;
  vec_t tbl[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_btns(input logic [2:0] b);
    {btn_reset, btn_szero, btn_madd} = b;
  endtask

  // Inputs were just changed after an edge; the next edge samples them.
  task automatic expect_issue(input string name, input logic [1:0] code);
    for (int i = 1; i <= 7; i++) tick();
    check({name, " pre-latency op"}, 32'(operation), 32'(2'b00));
    tick();
    check({name, " op"}, 32'(operation), 32'(code));
    check({name, " busy"}, 32'(busy), 32'd1);
    tick();
    check({name, " op one cycle"}, 32'(operation), 32'(2'b00));
    check({name, " ack"}, 32'(encoder_reset), 32'(ack_en));
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    check({name, " idle after release"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n0;
    tbl[0] = '{3'b001, 2'b10, "madd"};
    tbl[1] = '{3'b010, 2'b01, "szero"};
    tbl[2] = '{3'b100, 2'b11, "reset"};
    tbl[3] = '{3'b011, 2'b01, "szero+madd"};
    tbl[4] = '{3'b101, 2'b11, "reset+madd"};
    tbl[5] = '{3'b110, 2'b11, "reset+szero"};
    tbl[6] = '{3'b111, 2'b11, "all"};

    rst_n = 1'b0; ack_en = 1'b1; set_btns(3'b000);
    repeat (3) tick();
    check("reset op", 32'(operation), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset ack_err", 32'(ack_err), 32'd0);
    rst_n = 1'b1;
    repeat (5) tick();

    // Table: each pattern issues exactly one code by priority, held well past debounce
    foreach (tbl[i]) begin
      n0 = op_cnt;
      set_btns(tbl[i].btns);
      expect_issue(tbl[i].name, tbl[i].code);
      repeat (12) tick();
      check({tbl[i].name, " busy while held"}, 32'(busy), 32'd1);
      set_btns(3'b000);
      wait_idle(tbl[i].name);
      check({tbl[i].name, " single code"}, 32'(op_cnt), 32'(n0 + 1));
      check({tbl[i].name, " ack_err"}, 32'(ack_err), 32'd0);
    end

    // Short glitches never debounce
    n0 = op_cnt;
    for (int p = 0; p < 3; p++) begin
      set_btns(3'b010);
      repeat (2) tick();
      set_btns(3'b000);
      repeat (3) tick();
    end
    repeat (12) tick();
    check("glitch no code", 32'(op_cnt), 32'(n0));
    check("glitch busy", 32'(busy), 32'd0);

    // Second press during handshake is discarded; fresh press afterwards works
    n0 = op_cnt;
    set_btns(3'b010);
    expect_issue("szero first", 2'b01);
    set_btns(3'b011);
    repeat (15) tick();
    set_btns(3'b000);
    wait_idle("second press");
    check("second press ignored", 32'(op_cnt), 32'(n0 + 1));
    set_btns(3'b010);
    expect_issue("szero fresh", 2'b01);
    set_btns(3'b000);
    wait_idle("szero fresh");
    check("fresh press count", 32'(op_cnt), 32'(n0 + 2));

    // No acknowledge: sticky ack_err after the timeout window
    ack_en = 1'b0;
    set_btns(3'b001);
    expect_issue("noack", 2'b10);
    repeat (7) tick();
    check("ack_err before timeout", 32'(ack_err), 32'd0);
    tick();
    check("ack_err at timeout", 32'(ack_err), 32'd1);
    check("busy after timeout", 32'(busy), 32'd1);
    set_btns(3'b000);
    ack_en = 1'b1;
    wait_idle("noack");
    set_btns(3'b010);
    expect_issue("after ack_err", 2'b01);
    check("ack_err sticky", 32'(ack_err), 32'd1);
    set_btns(3'b000);
    wait_idle("after ack_err");

    // Reset mid-handshake with button held
    ack_en = 1'b0;
    set_btns(3'b001);
    expect_issue("pre-reset", 2'b10);
    repeat (2) tick();
    check("in wait_ack busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    check("midreset op", 32'(operation), 32'd0);
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset ack_err", 32'(ack_err), 32'd0);
    rst_n = 1'b1;
    ack_en = 1'b1;
    n0 = op_cnt;
    expect_issue("held through reset", 2'b10);
    set_btns(3'b000);
    wait_idle("held through reset");
    check("reissue count", 32'(op_cnt), 32'(n0 + 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
